// File: rtl/ifa_mem_target.sv
// ifa bus target: grants the bus, accepts an address phase, inserts
// WAIT_CYCLES wait states, then runs single or BURST_LEN-beat transfers
// against a local byte memory. Addresses >= DEPTH are unmapped and read as 8'hFF.
module ifa_mem_target #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int BURST_LEN   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_gnt,
    output logic       o_rdy,
    output logic [7:0] o_rdata,
    output logic       o_err
);

    localparam int         AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] LP_DEPTH      = 9'(DEPTH);
    localparam logic [7:0] LP_WAIT_INIT  = 8'(WAIT_CYCLES - 1);
    localparam logic [7:0] LP_BURST_LAST = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_addr_cur;
    logic [7:0] w_addr_cur_nxt;
    logic [1:0] r_mode;
    logic [1:0] w_mode_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    logic [7:0] r_beat_cnt;
    logic [7:0] w_beat_cnt_nxt;
    logic       w_last_beat;
    logic       w_mem_we;
    logic [7:0] w_rd_byte;
    logic [7:0] r_mem [DEPTH];
    logic       r_gnt;
    logic       r_rdy;
    logic [7:0] r_rdata;
    logic       r_err;

    function automatic logic is_mapped(input logic [7:0] a);
        is_mapped = ({1'b0, a} < LP_DEPTH);
    endfunction

    function automatic logic [AW-1:0] mem_idx(input logic [7:0] a);
        mem_idx = a[AW-1:0];
    endfunction

    // Next-state logic: handshake sequencing, address/beat/wait counters.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_cur_nxt = r_addr_cur;
        w_mode_nxt     = r_mode;
        w_wait_cnt_nxt = r_wait_cnt;
        w_beat_cnt_nxt = r_beat_cnt;
        w_mem_we       = 1'b0;
        w_last_beat    = (r_beat_cnt == (r_mode[1] ? LP_BURST_LAST : 8'd0));
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!i_req) begin
                    // req loses ownership even if start is asserted alongside it
                    w_state_nxt = ST_IDLE;
                end else if (i_start) begin
                    w_addr_cur_nxt = i_addr;
                    w_mode_nxt     = i_mode;
                    w_beat_cnt_nxt = 8'd0;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = LP_WAIT_INIT;
                    end
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 8'd0) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 8'd1;
                end
            end
            ST_DATA: begin
                w_mem_we       = r_mode[0] && is_mapped(r_addr_cur);
                w_addr_cur_nxt = r_addr_cur + 8'd1;
                w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                if (w_last_beat) begin
                    w_state_nxt = i_req ? ST_GRANT : ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read data for the beat presented in the next cycle; unmapped reads give 8'hFF.
    always_comb begin
        if (is_mapped(w_addr_cur_nxt)) begin
            w_rd_byte = r_mem[mem_idx(w_addr_cur_nxt)];
        end else begin
            w_rd_byte = 8'hFF;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_addr_cur <= 8'h00;
            r_mode     <= 2'b00;
            r_wait_cnt <= 8'd0;
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr_cur <= w_addr_cur_nxt;
            r_mode     <= w_mode_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Output registers, loaded from the state being entered so they align with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt   <= 1'b0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_gnt <= (w_state_nxt != ST_IDLE);
            r_rdy <= (w_state_nxt == ST_DATA);
            r_err <= (w_state_nxt == ST_DATA) && !is_mapped(w_addr_cur_nxt);
            if ((w_state_nxt == ST_DATA) && !w_mode_nxt[0]) begin
                r_rdata <= w_rd_byte;
            end
        end
    end

    // Byte memory: written at the end of each mapped write beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_mem_we) begin
            r_mem[mem_idx(r_addr_cur)] <= i_wdata;
        end
    end

    assign o_gnt   = r_gnt;
    assign o_rdy   = r_rdy;
    assign o_rdata = r_rdata;
    assign o_err   = r_err;

endmodule

// File: tb/tb_ifa_mem_target.sv
// Directed, table-driven bench for ifa_mem_target (DEPTH=16, WAIT_CYCLES=1, BURST_LEN=4).
module tb_ifa_mem_target;

    logic       i_clk;
    logic       i_rst;
    logic       i_req;
    logic       i_start;
    logic [1:0] i_mode;
    logic [7:0] i_addr;
    logic [7:0] i_wdata;
    logic       o_gnt;
    logic       o_rdy;
    logic [7:0] o_rdata;
    logic       o_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       req;
        logic       start;
        logic [1:0] mode;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       e_gnt;
        logic       e_rdy;
        logic [7:0] e_rdata;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    ifa_mem_target #(.DEPTH(16), .WAIT_CYCLES(1), .BURST_LEN(4)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req  (i_req),
        .i_start(i_start),
        .i_mode (i_mode),
        .i_addr (i_addr),
        .i_wdata(i_wdata),
        .o_gnt  (o_gnt),
        .o_rdy  (o_rdy),
        .o_rdata(o_rdata),
        .o_err  (o_err)
    );

    // Free-running clock, period 10.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic vec_t mkv(input logic req, input logic start, input logic [1:0] mode,
                                 input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic e_gnt, input logic e_rdy,
                                 input logic [7:0] e_rdata, input logic e_err);
        vec_t v;
        v.req = req; v.start = start; v.mode = mode; v.addr = addr; v.wdata = wdata;
        v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic g, input logic r,
                            input logic [7:0] d, input logic e);
        chk({tag, " gnt"},   {7'd0, o_gnt}, {7'd0, g});
        chk({tag, " rdy"},   {7'd0, o_rdy}, {7'd0, r});
        chk({tag, " rdata"}, o_rdata, d);
        chk({tag, " err"},   {7'd0, o_err}, {7'd0, e});
    endtask

    // Drive one vector, let one posedge sample it, then check the registered outputs.
    task automatic step(input string tag, input vec_t v);
        i_req   = v.req;
        i_start = v.start;
        i_mode  = v.mode;
        i_addr  = v.addr;
        i_wdata = v.wdata;
        @(posedge i_clk);
        #1;
        chk_outs(tag, v.e_gnt, v.e_rdy, v.e_rdata, v.e_err);
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_start = 1'b0;
        i_mode = 2'b00; i_addr = 8'h00; i_wdata = 8'h00;

        // single write 5A -> addr 03
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b1, 2'd1, 8'h03, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd1, 8'h03, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0));
        // single read addr 03
        tbl.push_back(mkv(1'b1, 1'b1, 2'd0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0));
        // burst write 11,22,33,44 at 0E (beats at 10/11 unmapped)
        tbl.push_back(mkv(1'b1, 1'b1, 2'd3, 8'h0E, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h11, 1'b1, 1'b1, 8'h5A, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h22, 1'b1, 1'b1, 8'h5A, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h33, 1'b1, 1'b1, 8'h5A, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h44, 1'b1, 1'b0, 8'h5A, 1'b0));
        // burst read at 0E -> 11,22,FF,FF; stray start during DATA is ignored
        tbl.push_back(mkv(1'b1, 1'b1, 2'd2, 8'h0E, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b1, 2'd1, 8'h03, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0));
        // burst write A1..A4 at FE wraps: mem[0]=A3, mem[1]=A4
        tbl.push_back(mkv(1'b1, 1'b1, 2'd3, 8'hFE, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'hA1, 1'b1, 1'b1, 8'hFF, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'hA2, 1'b1, 1'b1, 8'hFF, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'hA3, 1'b1, 1'b1, 8'hFF, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'hA4, 1'b1, 1'b0, 8'hFF, 1'b0));
        // burst read at FE wraps: FF,FF,A3,A4
        tbl.push_back(mkv(1'b1, 1'b1, 2'd2, 8'hFE, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b0));
        tbl.push_back(mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA4, 1'b0));
        // start with req=0 in GRANT -> IDLE, no transfer; start ignored in IDLE
        tbl.push_back(mkv(1'b0, 1'b1, 2'd0, 8'h03, 8'h00, 1'b0, 1'b0, 8'hA4, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b1, 2'd0, 8'h03, 8'h00, 1'b0, 1'b0, 8'hA4, 1'b0));

        // reset state
        repeat (2) @(negedge i_clk);
        chk_outs("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_outs("post-reset idle", 1'b0, 1'b0, 8'h00, 1'b0);

        for (int k = 0; k < tbl.size(); k++) begin
            step($sformatf("vec%0d", k), tbl[k]);
        end

        // req dropped during WAIT: read still completes, then IDLE
        step("reqdrop grant", mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA4, 1'b0));
        step("reqdrop start", mkv(1'b1, 1'b1, 2'd0, 8'h03, 8'h00, 1'b1, 1'b0, 8'hA4, 1'b0));
        step("reqdrop beat",  mkv(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0));
        step("reqdrop idle",  mkv(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0));

        // async reset after beat 2 of a burst write at 00
        step("rstmid grant", mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0));
        step("rstmid start", mkv(1'b1, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0));
        step("rstmid b0",    mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0));
        step("rstmid b1",    mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h77, 1'b1, 1'b1, 8'h5A, 1'b0));
        step("rstmid b2",    mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h88, 1'b1, 1'b1, 8'h5A, 1'b0));
        i_rst = 1'b1;
        i_req = 1'b0;
        #1;
        chk_outs("rstmid async", 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step("rbk grant", mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
        step("rbk start", mkv(1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
        for (int b = 0; b < 4; b++) begin
            step($sformatf("rbk beat%0d", b),
                 mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0));
        end
        step("rbk done", mkv(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifa_mem_target.md
Name: ifa_mem_target

Overview:
- Responder (target) end of the ifa bus. Answers initiator requests from a CPU core on the req/start/gnt/rdy handshake.
- Arbitrates with gnt, accepts an address phase, inserts programmable wait states, then completes single or 4-beat burst reads/writes against a local byte memory.
- Sits on the ifa bus opposite the CPU core's read/write tasks.

Parameters:
DEPTH, 16, number of implemented bytes; addresses >= DEPTH are unmapped
WAIT_CYCLES, 1, wait states between address phase and first data beat (0 allowed)
BURST_LEN, 4, beats per burst transfer (mode[1]=1)

Ports:
clk  input  1  bus clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
req  input  1  initiator requests bus ownership
start  input  1  address-phase strobe, valid only while gnt=1
mode  input  2  00 read single, 01 write single, 10 read burst, 11 write burst
addr  input  8  start address, sampled with start
wdata  input  8  initiator write data, sampled on each write beat while rdy=1
gnt  output  1  target has granted the bus
rdy  output  1  data beat completes this cycle
rdata  output  8  read data, valid while rdy=1 on reads
err  output  1  pulses with rdy when the beat address is unmapped

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, rdy=0, err=0, rdata=8'h00, all DEPTH memory bytes=8'h00, counters=0.
- All outputs are registered (decoded from registered state/data).
- IDLE: gnt=0. When req=1 at a posedge, go to GRANT; gnt=1 from the next cycle. start is ignored in IDLE.
- GRANT: gnt=1.
  - req=0 -> IDLE.
  - req=1 and start=1 -> latch addr and mode into addr_cur and mode_r; beat_cnt=0.
  - Then go to WAIT with wait_cnt=WAIT_CYCLES-1, or straight to DATA if WAIT_CYCLES=0.
- WAIT: gnt=1, rdy=0. Decrement wait_cnt; at 0 go to DATA. Wait states occur only before the first beat; burst beats are back-to-back.
- DATA: gnt=1, rdy=1 for exactly one cycle per beat.
  - Read beat: rdata=mem[addr_cur].
  - Write beat: mem[addr_cur]<=wdata at the end of the rdy cycle.
  - Unmapped address (addr_cur>=DEPTH): read returns 8'hFF, write is dropped, err=1 in that rdy cycle.
  - After each beat: addr_cur+1, 8-bit wrap (8'hFF -> 8'h00); beat_cnt+1.
  - Last beat (single: 1 beat; burst: BURST_LEN beats): go to GRANT if req=1, else IDLE.
- Latency: with WAIT_CYCLES=W, start sampled at posedge N gives the first rdy in cycle N+1+W.
- rdata holds its last read value outside read beats. Write beats leave rdata unchanged.
- req deasserted during WAIT/DATA: the transfer completes fully with no abort; return to IDLE afterwards.
- start asserted during WAIT/DATA: ignored. A back-to-back transfer needs a new start in GRANT.
- Simultaneous req=0 and start=1 in GRANT: req wins; go to IDLE with no transfer.
- mode bits: mode[0]=write, mode[1]=burst.
- rst asserted mid-transfer: immediate return to IDLE, outputs and memory to reset values; the partial burst is lost.

Test Plan:
- Reset then single write: req=1, then start with mode=01, addr=8'h03, wdata=8'h5A, W=1. Expect gnt the cycle after req, rdy 2 cycles after start, mem[3]=8'h5A.
- Single read: mode=00, addr=8'h03 after the previous write. Expect one rdy pulse with rdata=8'h5A, err=0; with req held, state returns to GRANT and gnt stays 1.
- Burst write then burst read: mode=11 at addr=8'h0E with wdata 11,22,33,44. Expect 4 consecutive rdy cycles, mem[E]=11 and mem[F]=22. Addresses 8'h10 and 8'h11 are unmapped, so beats 3-4 show err=1. Burst read returns 11,22,FF,FF.
- Address wrap: burst read at 8'hFE. Beat addresses FE,FF,00,01; rdata FF,FF,mem[0],mem[1]; err=1,1,0,0.
- Handshake edges:
  - req dropped in WAIT: the transfer still completes, then gnt=0.
  - start with req=0 in GRANT: no rdy, return to IDLE.
  - start pulse during DATA: ignored.
- Async reset mid-burst after beat 2 of a write: gnt/rdy drop to 0 immediately; the previously written bytes read back as 8'h00 after re-grant.
